// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned PC_INCR     = 4;
    localparam int unsigned DEF_ADDR_W  = 64;
    localparam int unsigned DEF_INSTR_W = 32;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Saturating 32-bit accumulate used by the statistics counters.
    function automatic logic [31:0] sat_add32(input logic [31:0] base, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, base} + {1'b0, inc};
        if (sum[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush; head is read straight from storage, no bypass.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  entry_t                    wdata,
    output entry_t                    head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == CNT_W'(0));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next-state for storage, pointers and occupancy; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC, 1-cycle imem issue, PC-tagged instruction FIFO, redirect flush.
// Optional FETCH_STATS_EN adds saturating fetched/flushed counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
`ifdef FETCH_STATS_EN
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_flushed,
`endif
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               inflight_q, inflight_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W:0]     occupancy;
    logic               issue;
    logic               push;
    logic               pop;
    logic               resp_live;
    entry_t             wr_entry;
    entry_t             head_entry;

    // Issue, response-write and handshake decisions for this cycle.
    always_comb begin
        occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
        issue     = !reset && !redirect_valid && !fifo_full && (occupancy < (CNT_W+1)'(DEPTH));
        resp_live = inflight_q && (state_q == RUN);
        push      = resp_live && !redirect_valid;
        pop       = !fifo_empty && instr_ready;
        wr_entry  = '{instr: imem_rdata, pc: inflight_pc_q};
    end

    // Next-state for the flush state machine, PC and in-flight tracking.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (redirect_valid) begin
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~ADDR_W'(3);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INCR);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
        if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end else begin
            inflight_d    = 1'b0;
            inflight_pc_d = inflight_pc_q;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= {ADDR_W{1'b0}};
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .head  (head_entry),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = !fifo_empty;
    assign instr       = head_entry.instr;
    assign instr_pc    = head_entry.pc;

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_q, stat_fetched_d;
    logic [31:0] stat_flushed_q, stat_flushed_d;
    logic [31:0] discard;

    // A pop in the redirect cycle is a real hand-off, so it is not counted as discarded.
    always_comb begin
        discard = 32'(fifo_count) + 32'(resp_live) - 32'(pop);
        if (pop) begin
            stat_fetched_d = sat_add32(stat_fetched_q, 32'd1);
        end else begin
            stat_fetched_d = stat_fetched_q;
        end
        if (redirect_valid) begin
            stat_flushed_d = sat_add32(stat_flushed_q, discard);
        end else begin
            stat_flushed_d = stat_flushed_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched_q <= 32'd0;
            stat_flushed_q <= 32'd0;
        end else begin
            stat_fetched_q <= stat_fetched_d;
            stat_flushed_q <= stat_flushed_d;
        end
    end

    assign stat_fetched = stat_fetched_q;
    assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue; a second instance covers RESET_PC wrap-around.
// Stat counter checks are compiled in when FETCH_STATS_EN is defined.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;

    logic        imem_req_w;
    logic [63:0] imem_addr_w;
    logic [31:0] imem_rdata_w;
    logic        instr_valid_w;
    logic [31:0] instr_w;
    logic [63:0] instr_pc_w;
    logic        redirect_w;

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_flushed, stat_fetched_w, stat_flushed_w;
`endif

    int          n_checks;
    int          n_pass;
    int          n_deliv;
    logic [63:0] sb [$];

    fetch_queue dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
`ifdef FETCH_STATS_EN
        .stat_fetched(stat_fetched), .stat_flushed(stat_flushed),
`endif
        .instr_pc(instr_pc)
    );

    fetch_queue #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .redirect_valid(redirect_w), .redirect_pc(64'd0),
        .instr_valid(instr_valid_w), .instr_ready(instr_ready), .instr(instr_w),
`ifdef FETCH_STATS_EN
        .stat_fetched(stat_fetched_w), .stat_flushed(stat_flushed_w),
`endif
        .instr_pc(instr_pc_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h5A5A_0000;
    endfunction

    // Instruction memory models: data for the address presented last cycle.
    always @(posedge clk) begin
        imem_rdata   <= instr_of(imem_addr);
        imem_rdata_w <= instr_of(imem_addr_w);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted instruction must match the next expected PC.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            check("sb_have_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                check("sb_pc", instr_pc, sb[0]);
                check("sb_instr", 64'(instr), 64'(instr_of(sb[0])));
                void'(sb.pop_front());
            end
            n_deliv++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        sb.delete();
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic push_stream(input logic [63:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            sb.push_back(base + 64'(4 * k));
        end
    endtask

    initial begin
        int base;
        int nreq;
        n_checks = 0; n_pass = 0; n_deliv = 0;
        reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 64'd0; redirect_w = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_pc", instr_pc, 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("first_req", 64'(imem_req), 64'd1);
        check("first_addr", imem_addr, 64'd0);

        // Streaming, latency, throughput and wrap-around instance
        do_reset(2);
        push_stream(64'd0, 30);
        instr_ready = 1'b1;
        base = n_deliv;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("strm_req0", 64'(imem_req), 64'd1);
                check("wrap_req0", 64'(imem_req_w), 64'd1);
                check("wrap_addr0", imem_addr_w, 64'hFFFF_FFFF_FFFF_FFFC);
            end
            if (i == 1) check("wrap_addr1", imem_addr_w, 64'd0);
            if (i == 2) begin
                check("wrap_pc0", instr_pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
                check("wrap_instr0", 64'(instr_w), 64'(instr_of(64'hFFFF_FFFF_FFFF_FFFC)));
            end
            if (i == 3) check("wrap_pc1", instr_pc_w, 64'd0);
            check("strm_valid", 64'(instr_valid), (i < 2) ? 64'd0 : 64'd1);
            tick();
        end
        check("strm_count", 64'(n_deliv - base), 64'd18);
`ifdef FETCH_STATS_EN
        check("stat_fetched_strm", 64'(stat_fetched), 64'd18);
`endif

        // Back-pressure: exactly DEPTH requests, stable head, in-order drain
        do_reset(1);
        push_stream(64'd0, 16);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req) begin
                check("stall_addr", imem_addr, 64'(4 * nreq));
                nreq++;
            end
            if (i >= 2) begin
                check("stall_valid", 64'(instr_valid), 64'd1);
                check("stall_head", instr_pc, 64'd0);
            end
            tick();
        end
        check("stall_nreq", 64'(nreq), 64'd4);
        base = n_deliv;
        instr_ready = 1'b1;
        repeat (12) begin
            @(negedge clk);
            tick();
        end
        check("drain_count", 64'(n_deliv - base), 64'd12);

        // Redirect with 3 queued entries and one fetch in flight
        do_reset(1);
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        @(negedge clk);
        check("redir_no_req", 64'(imem_req), 64'd0);
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        push_stream(64'h100, 12);
        base = n_deliv;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 0) begin
                check("redir_valid_low", 64'(instr_valid), 64'd0);
                check("redir_req", 64'(imem_req), 64'd1);
                check("redir_addr", imem_addr, 64'h100);
`ifdef FETCH_STATS_EN
                check("stat_flushed", 64'(stat_flushed), 64'd4);
`endif
            end
            tick();
        end
        check("redir_count", 64'(n_deliv - base), 64'd8);

        // Back-to-back redirects: last one wins
        do_reset(1);
        push_stream(64'd0, 10);
        instr_ready = 1'b1;
        repeat (5) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        tick();
        redirect_pc = 64'h300;
        sb.delete();
        push_stream(64'h300, 12);
        base = n_deliv;
        @(negedge clk);
        check("b2b_valid_low", 64'(instr_valid), 64'd0);
        check("b2b_no_req", 64'(imem_req), 64'd0);
        tick();
        redirect_valid = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 0) check("b2b_addr", imem_addr, 64'h300);
            tick();
        end
        check("b2b_count", 64'(n_deliv - base), 64'd8);

        // Reset pulsed while the FIFO is full
        do_reset(1);
        push_stream(64'd0, 20);
        instr_ready = 1'b1;
        repeat (6) tick();
        instr_ready = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("full_valid", 64'(instr_valid), 64'd1);
        check("full_head", instr_pc, 64'h10);
`ifdef FETCH_STATS_EN
        check("stat_fetched_pre", 64'(stat_fetched), 64'd4);
`endif
        tick();
        do_reset(1);
        push_stream(64'd0, 12);
        instr_ready = 1'b1;
        base = n_deliv;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 0) begin
                check("mrst_valid_low", 64'(instr_valid), 64'd0);
                check("mrst_req", 64'(imem_req), 64'd1);
                check("mrst_addr", imem_addr, 64'd0);
`ifdef FETCH_STATS_EN
                check("mrst_stat_fetched", 64'(stat_fetched), 64'd0);
                check("mrst_stat_flushed", 64'(stat_flushed), 64'd0);
`endif
            end
            tick();
        end
        check("mrst_count", 64'(n_deliv - base), 64'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage that sits directly upstream of decode/control.
- Owns the program counter and issues word-aligned addresses to a synchronous instruction memory with a fixed 1-cycle read latency.
- Buffers the returned instructions, each tagged with its PC, in a small FIFO that decode drains through a valid/ready handshake.
- Accepts branch redirects, which flush the FIFO and any in-flight fetch.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_W, 64, PC width.
- INSTR_W, 32, instruction width.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  ADDR_W  byte address of the request; bits [1:0] always 0.
- imem_rdata  in  INSTR_W  instruction, valid the cycle after imem_req.
- redirect_valid  in  1  branch taken; overrides everything else this cycle.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] are ignored and forced to 0.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decode accepts the head.
- instr  out  INSTR_W  head instruction.
- instr_pc  out  ADDR_W  PC of the head instruction.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - fetch_pc = RESET_PC; FIFO empty; inflight = 0.
  - imem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0.
  - First request goes out in the first cycle after reset deasserts.
  - Reset asserted mid-operation drops all queued and in-flight state.
- Issue rule:
  - imem_req = !reset && !redirect_valid && (count + inflight < DEPTH).
  - imem_addr = fetch_pc.
  - On issue: fetch_pc += 4 (wraps modulo 2^ADDR_W), and inflight <= 1 with inflight_pc <= fetch_pc.
  - Otherwise inflight <= 0.
- Response: when inflight = 1, the next cycle writes {imem_rdata, inflight_pc} into the FIFO tail. Space is guaranteed by the issue rule, so there is no overflow path.
- Handshake:
  - Transfer occurs when instr_valid && instr_ready.
  - instr and instr_pc are stable while instr_valid && !instr_ready.
  - instr_valid is never set combinationally from imem_rdata; minimum latency from request to instr_valid is 2 cycles (request, write, visible).
- Simultaneous push and pop: allowed when full or empty. Full with a pop in the same cycle leaves count unchanged. Empty FIFO gives no bypass.
- Throughput: sustains 1 instruction/cycle with DEPTH >= 2 and instr_ready held high.
- Redirect (redirect_valid = 1 in cycle N):
  - FIFO is flushed: count = 0, instr_valid = 0 in N+1.
  - Any response arriving in N+1 from a request issued in N-1 is discarded.
  - No request is issued in N.
  - fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; first request to the target goes out in N+1.
  - A handshake completing in cycle N still counts as consumed by decode.
  - Back-to-back redirects: the last one wins.
- Pointers: read/write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- State machine, 2 states:
  - RUN: normal operation.
  - FLUSH: entered on redirect, lasts exactly 1 cycle, discards the in-flight response, then returns to RUN.
  - A redirect during FLUSH re-enters FLUSH.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined: adds outputs stat_fetched[31:0] (instructions handed to decode) and stat_flushed[31:0] (entries plus in-flight responses discarded by redirects). Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters do not exist. Core behaviour is identical in both builds.

Decomposition:
- Package fetch_pkg holds:
  - PC_INCR = 4.
  - the fetch_state_e enum (RUN, FLUSH).
  - typedef fetch_entry_t = struct {instr, pc}.
- Sub-module sync_fifo (DEPTH, entry type):
  - inputs push, pop, flush.
  - outputs head, count, full, empty.
- fetch_queue holds the PC, inflight tracking, the state machine and the optional stats counters.

Test Plan:
- Reset, then instr_ready = 1 with imem returning mem[addr>>2] -> instr_pc sequence 0x0, 0x4, 0x8, ...; first instr_valid exactly 2 cycles after the first imem_req; one instruction per cycle thereafter.
- instr_ready = 0 for 10 cycles -> exactly 4 requests issued (0x0..0xC), then imem_req held at 0; head stays 0x0 stable; on release, drains in order with no loss or duplication.
- redirect_valid with redirect_pc = 0x103 while FIFO holds 3 entries and one fetch is in flight -> instr_valid = 0 next cycle; next imem_addr = 0x100; first delivered instr_pc = 0x100; no stale PC ever appears.
- Redirects in two consecutive cycles to 0x200 then 0x300 -> only the 0x300 stream is delivered.
- RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC -> PCs delivered as ...FFFC, then 0x0 (wrap-around).
- Reset pulsed mid-stream while the FIFO is full -> next cycle instr_valid = 0; restart from RESET_PC. With FETCH_STATS_EN, both stat counters read 0.
